dla_particle_walk: RTL and testbench

DLA_PARTICLE_WALK -- requirements
Module: dla_particle_walk

---
 rtl/dla_particle_walk.sv | 121 ++++++++++++
 tb/tb_dla_particle_walk.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dla_particle_walk.sv
// dla_particle_walk: random-walk one DLA particle from a random spawn point until it sticks, then write it to VRAM
// Ports: start launches a particle; step_limit caps the walk length (0 = unlimited);
// check_* is the handshake with an external neighbour/boundary checker; vram_avn_* is an Avalon write master.
`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 9
`endif
module dla_particle_walk #(
  parameter int          AVN_AW    = 19,
  parameter int          AVN_DW    = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         step_limit,
  output logic                busy,
  output logic                particle_done,
  output logic [15:0]         particle_cnt,
  output logic [`H_SIZE-1:0]  check_x,
  output logic [`V_SIZE-1:0]  check_y,
  output logic                check_start,
  input  logic                check_done,
  input  logic                hit_boundary,
  input  logic                hit_neighbor,
  output logic [AVN_AW-1:0]   vram_avn_address,
  output logic                vram_avn_write,
  output logic [AVN_DW-1:0]   vram_avn_writedata,
  input  logic                vram_avn_waitrequest
);
  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    SPAWN = 7'b0000010,
    CHECK = 7'b0000100,
    WAIT  = 7'b0001000,
    STEP  = 7'b0010000,
    WRITE = 7'b0100000,
    DONE  = 7'b1000000
  } state_t;
  localparam logic [`H_SIZE-1:0] X_MAX = `H_SIZE'(`H_DISPLAY - 2);
  localparam logic [`V_SIZE-1:0] Y_MAX = `V_SIZE'(`V_DISPLAY - 2);
  localparam logic [AVN_AW-1:0]  H_DISP = AVN_AW'(`H_DISPLAY);
  state_t              state_q, state_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [`H_SIZE-1:0]  x_q, x_d, cand_x;
  logic [`V_SIZE-1:0]  y_q, y_d, cand_y;
  logic [15:0]         step_q, step_d, cnt_q, cnt_d;
  logic                cand_ok, limit_hit;
  assign cand_x    = lfsr_q[`H_SIZE-1:0];
  assign cand_y    = lfsr_q[31:32-`V_SIZE];
  assign cand_ok   = cand_x != '0 && cand_x <= X_MAX && cand_y != '0 && cand_y <= Y_MAX;
  assign limit_hit = step_limit != '0 && step_q == step_limit;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    // Galois right-shift form of x^32+x^22+x^2+x+1
    lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    unique case (state_q)
      IDLE:  state_d = start ? SPAWN : IDLE;
      SPAWN: if (cand_ok) begin
        x_d     = cand_x;
        y_d     = cand_y;
        step_d  = '0;
        state_d = CHECK;
      end
      CHECK: state_d = WAIT;
      WAIT:  if (check_done)
        state_d = hit_boundary ? SPAWN : hit_neighbor ? WRITE : limit_hit ? SPAWN : STEP;
      STEP: begin
        // no clamping: stepping off the field is reported by the checker as a boundary hit
        x_d     = lfsr_q[1:0] == 2'd0 ? x_q + 1'b1 : lfsr_q[1:0] == 2'd1 ? x_q - 1'b1 : x_q;
        y_d     = lfsr_q[1:0] == 2'd2 ? y_q + 1'b1 : lfsr_q[1:0] == 2'd3 ? y_q - 1'b1 : y_q;
        step_d  = &step_q ? step_q : step_q + 16'd1;
        state_d = CHECK;
      end
      WRITE: state_d = vram_avn_waitrequest ? WRITE : DONE;
      DONE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      x_q     <= '0;
      y_q     <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy               = state_q != IDLE;
  assign check_start        = state_q == CHECK;
  assign vram_avn_write     = state_q == WRITE;
  assign particle_done      = state_q == DONE;
  assign particle_cnt       = cnt_q;
  assign check_x            = x_q;
  assign check_y            = y_q;
  assign vram_avn_address   = AVN_AW'(x_q) + AVN_AW'(y_q) * H_DISP;
  assign vram_avn_writedata = {AVN_DW{vram_avn_write}};
endmodule

// File: tb/tb_dla_particle_walk.sv
// tb_dla_particle_walk: directed bench for dla_particle_walk with a scripted checker and Avalon slave
module tb_dla_particle_walk;
  logic        clk = 0, rst = 1, start = 0;
  logic [15:0] step_limit = 0;
  logic        busy, particle_done, check_start;
  logic [15:0] particle_cnt;
  logic [9:0]  check_x;
  logic [8:0]  check_y;
  logic        check_done = 0, hit_boundary = 0, hit_neighbor = 0;
  logic [18:0] vram_avn_address;
  logic        vram_avn_write;
  logic [15:0] vram_avn_writedata;
  logic        vram_avn_waitrequest = 0;
  dla_particle_walk dut (
    .clk(clk), .rst(rst), .start(start), .step_limit(step_limit),
    .busy(busy), .particle_done(particle_done), .particle_cnt(particle_cnt),
    .check_x(check_x), .check_y(check_y), .check_start(check_start),
    .check_done(check_done), .hit_boundary(hit_boundary), .hit_neighbor(hit_neighbor),
    .vram_avn_address(vram_avn_address), .vram_avn_write(vram_avn_write),
    .vram_avn_writedata(vram_avn_writedata), .vram_avn_waitrequest(vram_avn_waitrequest)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int mdist(input int ax, input int ay, input int bx, input int by);
    int dx, dy;
    dx = (ax - bx) & 1023;
    dy = (ay - by) & 511;
    dx = dx > 512 ? 1024 - dx : dx;
    dy = dy > 256 ? 512 - dy : dy;
    return dx + dy;
  endfunction
  int nchk = 0, nbr_at = 0, bnd_at = 0, snap_at = 0;
  bit do_manh = 0;
  int last_x = 0, last_y = 0, first_x = 0, first_y = 0;
  int snap_dist = 0, snap_acc = 0, snap_cnt = 0, snap_x = 0, snap_y = 0;
  int wr_hold = 0, wr_cycles = 0, acc_cnt = 0;
  logic [31:0] acc_addr = 0, wr_addr0 = 0;
  // checker model: answers each check_start two cycles later
  initial forever begin
    @(negedge clk);
    if (check_start === 1'b1) begin
      int cx, cy, d;
      cx = int'(check_x);
      cy = int'(check_y);
      nchk++;
      d = mdist(cx, cy, last_x, last_y);
      if (nchk == 1) begin
        first_x = cx;
        first_y = cy;
      end
      if (do_manh && nchk > 1) chk("manhattan", d, 1);
      if (nchk == snap_at) begin
        snap_dist = d;
        snap_acc  = acc_cnt;
        snap_cnt  = int'(particle_cnt);
        snap_x    = cx;
        snap_y    = cy;
      end
      last_x = cx;
      last_y = cy;
      @(negedge clk);
      chk("cs_pulse", check_start, 0);
      chk("pos_hold", 32'(check_y) * 1024 + 32'(check_x), cy * 1024 + cx);
      @(negedge clk);
      check_done   = 1;
      hit_boundary = nchk == bnd_at;
      hit_neighbor = nchk == nbr_at;
      @(negedge clk);
      check_done   = 0;
      hit_boundary = 0;
      hit_neighbor = 0;
    end
  end
  // Avalon slave: stalls wr_hold cycles, then accepts
  initial forever begin
    @(negedge clk);
    if (vram_avn_write === 1'b1) begin
      chk("wr_excl", check_start, 0);
      if (wr_cycles == 0) wr_addr0 = 32'(vram_avn_address);
      else chk("wr_addr_hold", vram_avn_address, wr_addr0);
      chk("wr_data", vram_avn_writedata, 32'h0000_FFFF);
      wr_cycles++;
      if (wr_hold > 0) begin
        vram_avn_waitrequest = 1;
        wr_hold--;
      end else begin
        vram_avn_waitrequest = 0;
        acc_cnt++;
        acc_addr = 32'(vram_avn_address);
      end
    end else vram_avn_waitrequest = 0;
  end
  task automatic launch(input int nb, input int bd, input int sn, input bit mh);
    nchk = 0; nbr_at = nb; bnd_at = bd; snap_at = sn; do_manh = mh; wr_cycles = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (particle_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, particle_done, 1);
  endtask
  int acc0, k;
  initial begin
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", particle_done, 0);
    chk("rst_cs", check_start, 0);
    chk("rst_wr", vram_avn_write, 0);
    chk("rst_cnt", particle_cnt, 0);
    chk("rst_x", check_x, 0);
    chk("rst_y", check_y, 0);
    chk("rst_addr", vram_avn_address, 0);
    chk("rst_wdata", vram_avn_writedata, 0);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    // immediate stick at spawn point
    acc0 = acc_cnt;
    launch(1, 0, 0, 0);
    wait_done("s1_done");
    chk("s1_checks", nchk, 1);
    chk("s1_writes", acc_cnt - acc0, 1);
    chk("s1_addr", acc_addr, (last_x + last_y * 640) & 32'h7FFFF);
    chk("s1_spawn_x", first_x >= 1 && first_x <= 638, 1);
    chk("s1_spawn_y", first_y >= 1 && first_y <= 478, 1);
    @(negedge clk);
    chk("s1_cnt", particle_cnt, 1);
    chk("s1_idle", busy, 0);
    // five plain steps then stick
    acc0 = acc_cnt;
    launch(6, 0, 0, 1);
    wait_done("s2_done");
    chk("s2_checks", nchk, 6);
    chk("s2_writes", acc_cnt - acc0, 1);
    chk("s2_addr", acc_addr, (last_x + last_y * 640) & 32'h7FFFF);
    @(negedge clk);
    chk("s2_cnt", particle_cnt, 2);
    // boundary on third check forces respawn
    acc0 = acc_cnt;
    launch(5, 3, 4, 0);
    wait_done("s3_done");
    chk("s3_checks", nchk, 5);
    chk("s3_nowrite_before", snap_acc - acc0, 0);
    chk("s3_cnt_before", snap_cnt, 2);
    chk("s3_respawn_x", snap_x >= 1 && snap_x <= 638, 1);
    chk("s3_respawn_y", snap_y >= 1 && snap_y <= 478, 1);
    chk("s3_writes", acc_cnt - acc0, 1);
    @(negedge clk);
    chk("s3_cnt", particle_cnt, 3);
    // step limit: respawn after fifth check_done
    step_limit = 16'd4;
    acc0 = acc_cnt;
    launch(6, 0, 6, 0);
    wait_done("s4_done");
    chk("s4_checks", nchk, 6);
    chk("s4_nowrite_before", snap_acc - acc0, 0);
    chk("s4_cnt_before", snap_cnt, 3);
    chk("s4_respawn_jump", snap_dist != 1, 1);
    chk("s4_respawn_x", snap_x >= 1 && snap_x <= 638, 1);
    @(negedge clk);
    chk("s4_cnt", particle_cnt, 4);
    step_limit = 16'd0;
    // stalled write with a stray start pulse
    acc0 = acc_cnt;
    wr_hold = 7;
    launch(1, 0, 0, 0);
    k = 0;
    while (vram_avn_write !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("s5_write_seen", vram_avn_write, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("s5_done");
    chk("s5_wr_cycles", wr_cycles, 8);
    chk("s5_writes", acc_cnt - acc0, 1);
    repeat (6) @(negedge clk);
    chk("s5_ignored_start", busy, 0);
    chk("s5_no_recheck", nchk, 1);
    chk("s5_cnt", particle_cnt, 5);
    // reset while waiting on the checker
    acc0 = acc_cnt;
    launch(0, 0, 0, 0);
    k = 0;
    while (k < 3) begin
      @(negedge clk);
      if (check_start === 1'b1) k++;
    end
    @(negedge clk);
    chk("s6_in_wait", busy, 1);
    #2 rst = 0;
    #1;
    chk("s6_async_busy", busy, 0);
    chk("s6_async_cnt", particle_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (20) @(negedge clk);
    chk("s6_no_write", acc_cnt - acc0, 0);
    chk("s6_idle", busy, 0);
    // fresh start after reset
    acc0 = acc_cnt;
    launch(1, 0, 0, 0);
    wait_done("s7_done");
    chk("s7_writes", acc_cnt - acc0, 1);
    chk("s7_addr", acc_addr, (last_x + last_y * 640) & 32'h7FFFF);
    @(negedge clk);
    chk("s7_cnt", particle_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
